// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path: the sequencer state encoding,
// the opcode classes reported by the instruction decoder, and small
// opcode-classification helpers used by the sequencer and the PC unit.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Sequencer phases. An instruction walks FETCH_REQ -> FETCH_WAIT -> DECODE ->
  // EXEC -> [MEM_REQ -> MEM_WAIT ->] WB, with an optional INT_ENTRY between
  // instructions. HALTED is terminal until reset.
  typedef enum logic [3:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    INT_ENTRY,
    HALTED
  } state_t;

  // Opcode classes driven on instrOP by the decoder.
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] OP_RETI  = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1101;

  // Instructions that need a data-bus transaction after EXEC.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Instructions that produce a register-file result.
  function automatic logic writes_back(input logic [3:0] op);
    return !((op == OP_STORE) || (op == OP_HALT) || (op == OP_RETI));
  endfunction

  // Instructions whose boundary may not be used for interrupt entry:
  // HALT stops the core, RETI must complete its return first.
  function automatic logic blocks_irq(input logic [3:0] op);
    return (op == OP_HALT) || (op == OP_RETI);
  endfunction

endpackage

// File: rtl/cpu_pc_unit.sv
// -----------------------------------------------------------------------------
// cpu_pc_unit
// Program counter register and its update rules.
//
// Ports:
//   clk, reset   system clock, asynchronous active-low reset
//   wb_step      1 in the writeback cycle: pc takes pc_next
//   op           opcode class of the instruction being retired
//   jump_en      datapath request to take jump_addr
//   jump_addr    jump / branch / return target
//   int_entry    1 in the interrupt-entry cycle: pc takes INT_VECTOR
//   save_en      capture the post-writeback pc as the interrupt return address
//   pc           current instruction address
//   save_pc      interrupt return address
// -----------------------------------------------------------------------------
module cpu_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = 27,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_step,
  input  logic [3:0]      op,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            int_entry,
  input  logic            save_en,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] save_pc
);

  logic [PC_W-1:0] pc_next;

  // Priority: HALT holds, RETI or a taken jump loads the target, otherwise
  // the next sequential word. The add wraps naturally at 2^PC_W.
  always_comb begin
    // NOTE: the default is assigned before any condition so that every path
    // writes pc_next; a missing path would infer a latch.
    pc_next = pc + PC_W'(1);
    if (op == OP_HALT) begin
      pc_next = pc;
    end else if ((op == OP_RETI) || jump_en) begin
      pc_next = jump_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of the order
  // of statements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      save_pc <= '0;
    end else begin
      if (int_entry) begin
        pc <= INT_VECTOR;
      end else if (wb_step) begin
        pc <= pc_next;
      end
      // save_pc is captured at the end of WB, so during INT_ENTRY it already
      // holds the address of the instruction after the interrupted one.
      if (save_en) begin
        save_pc <= pc_next;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM of the CPU. Sequences instruction fetch over the
// shared memory bus, strobes the decoder, enables execute / memory /
// writeback, and performs interrupt entry and return at instruction
// boundaries. The PC lives in cpu_pc_unit.
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   bus_start          one-cycle bus request pulse
//   bus_we             bus write enable, qualifies bus_start
//   bus_addr           bus address, stable from bus_start until bus_done
//   bus_done           one-cycle bus completion pulse
//   fetch              decoder pass-through strobe (fetch in flight)
//   getRegs            decoder instruction latch strobe
//   instrOP            opcode class from the decoder
//   mem_addr           load/store address from the datapath
//   jump_en, jump_addr datapath jump request and target, sampled in WB
//   exec_en            datapath execute strobe
//   wb_en              register-file writeback strobe
//   irq                level interrupt request, sampled in WB only
//   int_ack, save_pc   interrupt entry pulse and return address
//   pc                 current instruction address
//   halted             core stopped until reset
//
// All outputs are decodes of registered state; bus_done only affects the
// next-state logic, so there is no combinational bus_done -> bus_start path.
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = 27,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            bus_start,
  output logic            bus_we,
  output logic [PC_W-1:0] bus_addr,
  input  logic            bus_done,
  output logic            fetch,
  output logic            getRegs,
  input  logic [3:0]      instrOP,
  input  logic [PC_W-1:0] mem_addr,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic            exec_en,
  output logic            wb_en,
  input  logic            irq,
  output logic            int_ack,
  output logic [PC_W-1:0] save_pc,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t          state, next_state;
  logic            run_q;       // 0 while in reset and until the first edge after release
  logic            int_busy;    // inside an interrupt handler: nesting blocked
  logic [3:0]      op_q;        // opcode class of the instruction in flight
  logic [PC_W-1:0] mem_addr_q;  // load/store address, held for the whole access

  // ---------------------------------------------------------------------------
  // State register and instruction context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH_REQ;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      int_busy   <= 1'b0;
      // NOTE: the captured opcode and address are reset as well; they feed
      // output decodes, so leaving them unknown would put X on bus_we/bus_addr.
      op_q       <= '0;
      mem_addr_q <= '0;
    end else begin
      run_q <= 1'b1;
      // The decoder output is valid from EXEC onwards; capturing it here keeps
      // MEM_REQ/MEM_WAIT/WB outputs independent of later datapath activity.
      if (state == EXEC) begin
        op_q       <= instrOP;
        mem_addr_q <= mem_addr;
      end
      if (state == INT_ENTRY) begin
        int_busy <= 1'b1;
      end else if ((state == WB) && (op_q == OP_RETI)) begin
        int_busy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    bus_start  = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = pc;
    fetch      = 1'b0;
    getRegs    = 1'b0;
    exec_en    = 1'b0;
    wb_en      = 1'b0;
    int_ack    = 1'b0;
    halted     = 1'b0;

    unique case (state)
      FETCH_REQ: begin
        // Held here for the single edge that releases reset, so the first
        // visible cycle after release issues the fetch.
        bus_start = run_q;
        if (run_q) begin
          next_state = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        fetch = 1'b1;
        if (bus_done) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        getRegs    = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        exec_en    = 1'b1;
        next_state = is_mem_op(instrOP) ? MEM_REQ : WB;
      end
      MEM_REQ: begin
        bus_start  = 1'b1;
        bus_addr   = mem_addr_q;
        bus_we     = (op_q == OP_STORE);
        next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        bus_addr = mem_addr_q;
        bus_we   = (op_q == OP_STORE);
        if (bus_done) begin
          next_state = WB;
        end
      end
      WB: begin
        wb_en = writes_back(op_q);
        if (op_q == OP_HALT) begin
          next_state = HALTED;
        end else if (irq && !int_busy && !blocks_irq(op_q)) begin
          next_state = INT_ENTRY;
        end else begin
          next_state = FETCH_REQ;
        end
      end
      INT_ENTRY: begin
        int_ack    = 1'b1;
        next_state = FETCH_REQ;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        next_state = FETCH_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  cpu_pc_unit #(
    .PC_W       (PC_W),
    .RESET_PC   (RESET_PC),
    .INT_VECTOR (INT_VECTOR)
  ) u_pc_unit (
    .clk       (clk),
    .reset     (reset),
    .wb_step   (state == WB),
    .op        (op_q),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .int_entry (state == INT_ENTRY),
    .save_en   ((state == WB) && (next_state == INT_ENTRY)),
    .pc        (pc),
    .save_pc   (save_pc)
  );

endmodule
